rx_os_tracker: RTL and testbench
================================

RX_OS_TRACKER -- requirements
Module: rx_os_tracker

Interface
REQ-001 Parameter SLOS_REQ, default 2: consecutive-detection count required per lane for SLOS1/SLOS2 (codes 0,1).
REQ-002 Parameter TS_REQ, default 4: count required per lane for Gen3/Gen4 TS codes (2..7).
REQ-003 Parameter TIMEOUT_CYC, default 1000: TRACK-state cycle budget; range 2..65535.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 track_en  input  1  LTSSM request to track the expected ordered set.
REQ-007 exp_os  input  4  expected code: 0 SLOS1, 1 SLOS2, 2-3 Gen3 TS1/TS2, 4-7 Gen4 TS1-TS4, 8 data; 9-15 invalid.
REQ-008 lane1_en  input  1  1 = both lanes must qualify; 0 = lane 0 only.
REQ-009 os_in_l0  input  4  per-cycle lane 0 detection code from data_bus_receive; 9 = none.
REQ-010 os_in_l1  input  4  per-cycle lane 1 detection code; 9 = none.
REQ-011 d_sel  output  4  registered selector to data_bus_receive.
REQ-012 lane_rx_on  output  1  receive enable to data_bus_receive.
REQ-013 os_done  output  1  level: required count reached on required lanes.
REQ-014 os_timeout  output  1  level: TIMEOUT_CYC expired before os_done.

Function
REQ-015 States SHALL be IDLE, ARM, TRACK, DATA, DONE, TOUT.
REQ-016 IDLE -> ARM when track_en=1 and exp_os<=7; IDLE -> DATA when track_en=1 and exp_os=8; exp_os 9-15 treated as track_en=0.
REQ-017 On leaving IDLE, d_sel SHALL latch exp_os; d_sel holds until next latch.
REQ-018 ARM SHALL last exactly one cycle, clear both lane counters and the timeout counter, assert lane_rx_on, then go TRACK.
REQ-019 In TRACK, lane counter n SHALL increment when os_in_ln == d_sel, saturating at the required count.
REQ-020 In TRACK, os_in_ln == 9 SHALL leave counter n unchanged.
REQ-021 In TRACK, os_in_ln neither 9 nor d_sel SHALL clear counter n to 0 that cycle.
REQ-022 Required count = SLOS_REQ for d_sel 0-1, TS_REQ for d_sel 2-7.
REQ-023 Counter updates in cycle k SHALL be evaluated for completion in cycle k+1; TRACK -> DONE when cnt_l0 reached and (cnt_l1 reached or lane1_en=0).
REQ-024 Timeout counter SHALL increment every TRACK cycle; TRACK -> TOUT when it reaches TIMEOUT_CYC-1 and completion not met.
REQ-025 Completion and timeout in the same cycle: DONE wins.
REQ-026 lane_rx_on SHALL be 1 in ARM, TRACK, DATA; 0 in IDLE, DONE, TOUT.
REQ-027 os_done = 1 only in DONE; os_timeout = 1 only in TOUT; never both.
REQ-028 DONE, TOUT, DATA: exp_os differing from d_sel with track_en=1 -> re-latch and go ARM (or DATA for code 8).
REQ-029 Any state: track_en=0 -> IDLE next cycle, counters cleared, outputs deasserted next cycle.
REQ-030 TRACK: exp_os change with track_en=1 -> re-latch d_sel and go ARM (restart, counters cleared).
REQ-031 DATA: no counting, os_done stays 0, timeout counter idle.
REQ-032 lane1_en SHALL be sampled live each TRACK cycle.

Reset
REQ-033 rst=0 SHALL force IDLE asynchronously; d_sel=9, lane_rx_on=0, os_done=0, os_timeout=0, all counters 0.
REQ-034 Reset asserted mid-TRACK SHALL abort immediately; after release, tracking restarts only via IDLE -> ARM.

Verification
REQ-035 track_en=1, exp_os=2, lane1_en=1, both lanes report 2 on 4 cycles (gaps of 9 allowed) -> d_sel=2, lane_rx_on=1, os_done=1 one cycle after 4th hit, lane_rx_on=0.
REQ-036 exp_os=0, lane 0 reports 0,0, lane 1 reports 0,3,0 -> lane 1 counter reset; os_done only after lane 1 reaches 2 further hits.
REQ-037 TIMEOUT_CYC=10, exp_os=5, no detections -> os_timeout=1 after 10 TRACK cycles, os_done=0.
REQ-038 lane1_en=0, exp_os=4, lane 0 reaches TS_REQ, lane 1 silent -> os_done=1.
REQ-039 Completion and timeout coincide -> os_done=1, os_timeout=0.
REQ-040 rst pulsed low mid-TRACK -> all outputs reset values immediately; exp_os=8 afterwards -> DATA, lane_rx_on=1, d_sel=8, os_done=0.

Source files
------------

// File: rtl/rx_os_tracker.sv
// -----------------------------------------------------------------------------
// rx_os_tracker
//
// Purpose:
//   Tracks ordered-set detections reported per lane by data_bus_receive on
//   behalf of the LTSSM. On a tracking request the expected code is latched
//   onto d_sel and the receiver is enabled. Consecutive detections are then
//   counted on lane 0 and, if lane1_en is set, on lane 1 as well. When the
//   required count is reached the block reports os_done. If the TRACK cycle
//   budget runs out first, it reports os_timeout. Code 8 (data) only enables
//   the receiver and does no counting.
//
// Ports:
//   clk         in   1  single clock, rising edge
//   rst         in   1  asynchronous active-low reset
//   track_en    in   1  request to track exp_os
//   exp_os      in   4  expected code (0-1 SLOS, 2-7 TS, 8 data, 9-15 invalid)
//   lane1_en    in   1  1: both lanes must qualify, 0: lane 0 only
//   os_in_l0    in   4  lane 0 detection code per cycle (9 = none)
//   os_in_l1    in   4  lane 1 detection code per cycle (9 = none)
//   d_sel       out  4  registered selector to data_bus_receive
//   lane_rx_on  out  1  receive enable to data_bus_receive
//   os_done     out  1  level: required count reached on required lanes
//   os_timeout  out  1  level: cycle budget expired before completion
// -----------------------------------------------------------------------------
module rx_os_tracker #(
    parameter int SLOS_REQ    = 2,
    parameter int TS_REQ      = 4,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       track_en,
    input  logic [3:0] exp_os,
    input  logic       lane1_en,
    input  logic [3:0] os_in_l0,
    input  logic [3:0] os_in_l1,
    output logic [3:0] d_sel,
    output logic       lane_rx_on,
    output logic       os_done,
    output logic       os_timeout
);

    localparam int MAX_REQ = (SLOS_REQ > TS_REQ) ? SLOS_REQ : TS_REQ;
    localparam int CW      = $clog2(MAX_REQ + 1);

    localparam logic [CW-1:0] SLOS_N   = CW'(SLOS_REQ);
    localparam logic [CW-1:0] TS_N     = CW'(TS_REQ);
    localparam logic [15:0]   TMO_LAST = 16'(TIMEOUT_CYC - 1);

    localparam logic [3:0] CODE_LAST_SLOS = 4'd1;
    localparam logic [3:0] CODE_DATA      = 4'd8;
    localparam logic [3:0] CODE_NONE      = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_TRACK = 3'd2,
        S_DATA  = 3'd3,
        S_DONE  = 3'd4,
        S_TOUT  = 3'd5
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt_l0;
    logic [CW-1:0]   r_cnt_l1;
    logic [15:0]     r_tmo;

    logic            w_go;
    logic            w_restart;
    logic [CW-1:0]   w_req;
    logic            w_complete;
    logic            w_tmo_last;
    logic [CW-1:0]   w_nxt_l0;
    logic [CW-1:0]   w_nxt_l1;

    // Next value of one lane counter: a match counts up (saturating at the
    // required count), "none" holds, any other code breaks the run.
    function automatic logic [CW-1:0] next_cnt(
        input logic [3:0]    code,
        input logic [3:0]    sel,
        input logic [CW-1:0] cnt,
        input logic [CW-1:0] req
    );
        logic [CW-1:0] res;
        if (code == sel) begin
            if (cnt < req) begin
                res = cnt + CW'(1);
            end else begin
                res = cnt;
            end
        end else if (code == CODE_NONE) begin
            res = cnt;
        end else begin
            res = '0;
        end
        return res;
    endfunction

    // Qualification and counter-update terms used by the state machine.
    always_comb begin
        // Codes 9-15 are handled exactly like a dropped request.
        w_go       = track_en & (exp_os <= CODE_DATA);
        // ARM is excluded: it always proceeds to TRACK, where a changed
        // exp_os then restarts tracking.
        w_restart  = (r_state != S_IDLE) & (r_state != S_ARM) & (exp_os != d_sel);
        w_req      = (d_sel <= CODE_LAST_SLOS) ? SLOS_N : TS_N;
        // Uses the counts registered last cycle, so a hit is judged one
        // cycle after it is counted.
        w_complete = (r_cnt_l0 >= w_req) & ((r_cnt_l1 >= w_req) | ~lane1_en);
        w_tmo_last = (r_tmo == TMO_LAST);
        w_nxt_l0   = next_cnt(os_in_l0, d_sel, r_cnt_l0, w_req);
        w_nxt_l1   = next_cnt(os_in_l1, d_sel, r_cnt_l1, w_req);
    end

    // Tracker state machine with registered selector and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt_l0   <= '0;
            r_cnt_l1   <= '0;
            r_tmo      <= 16'd0;
            d_sel      <= CODE_NONE;
            lane_rx_on <= 1'b0;
            os_done    <= 1'b0;
            os_timeout <= 1'b0;
        end else if (!w_go) begin
            r_state    <= S_IDLE;
            r_cnt_l0   <= '0;
            r_cnt_l1   <= '0;
            r_tmo      <= 16'd0;
            lane_rx_on <= 1'b0;
            os_done    <= 1'b0;
            os_timeout <= 1'b0;
        end else if ((r_state == S_IDLE) || w_restart) begin
            // Latch a new request, or a changed one, and start over.
            d_sel      <= exp_os;
            r_state    <= (exp_os == CODE_DATA) ? S_DATA : S_ARM;
            r_cnt_l0   <= '0;
            r_cnt_l1   <= '0;
            r_tmo      <= 16'd0;
            lane_rx_on <= 1'b1;
            os_done    <= 1'b0;
            os_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_ARM: begin
                    r_state    <= S_TRACK;
                    r_cnt_l0   <= '0;
                    r_cnt_l1   <= '0;
                    r_tmo      <= 16'd0;
                    lane_rx_on <= 1'b1;
                    os_done    <= 1'b0;
                    os_timeout <= 1'b0;
                end
                S_TRACK: begin
                    // Completion has priority over an expiring budget.
                    if (w_complete) begin
                        r_state    <= S_DONE;
                        lane_rx_on <= 1'b0;
                        os_done    <= 1'b1;
                        os_timeout <= 1'b0;
                    end else if (w_tmo_last) begin
                        r_state    <= S_TOUT;
                        lane_rx_on <= 1'b0;
                        os_done    <= 1'b0;
                        os_timeout <= 1'b1;
                    end else begin
                        r_state    <= S_TRACK;
                        r_cnt_l0   <= w_nxt_l0;
                        r_cnt_l1   <= w_nxt_l1;
                        r_tmo      <= r_tmo + 16'd1;
                        lane_rx_on <= 1'b1;
                    end
                end
                S_DATA, S_DONE, S_TOUT: begin
                    r_state <= r_state;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_cnt_l0   <= '0;
                    r_cnt_l1   <= '0;
                    r_tmo      <= 16'd0;
                    lane_rx_on <= 1'b0;
                    os_done    <= 1'b0;
                    os_timeout <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_os_tracker.sv
// -----------------------------------------------------------------------------
// tb_rx_os_tracker
//
// Self-checking bench for rx_os_tracker. A behavioural model keeps the lane
// detection history of the current tracking attempt in queues. It derives the
// hit counts from the run of matches since the last disruptive code, and the
// elapsed budget from the history length. One process compares every cycle;
// directed scenarios add literal expectations; a random phase follows.
// -----------------------------------------------------------------------------
module tb_rx_os_tracker;

    localparam int SLOS_REQ    = 2;
    localparam int TS_REQ      = 4;
    localparam int TIMEOUT_CYC = 10;

    localparam int PH_IDLE  = 0;
    localparam int PH_ARM   = 1;
    localparam int PH_TRACK = 2;
    localparam int PH_DATA  = 3;
    localparam int PH_DONE  = 4;
    localparam int PH_TOUT  = 5;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       track_en = 1'b0;
    logic [3:0] exp_os   = 4'd9;
    logic       lane1_en = 1'b0;
    logic [3:0] os_in_l0 = 4'd9;
    logic [3:0] os_in_l1 = 4'd9;
    logic [3:0] d_sel;
    logic       lane_rx_on;
    logic       os_done;
    logic       os_timeout;
    logic [6:0] w_dut;

    int   n_cmp  = 0;
    int   n_err  = 0;
    bit   cmp_en = 1'b0;

    // Model state: phase, latched selector, per-lane history since TRACK began
    int         m_phase = PH_IDLE;
    logic [3:0] m_sel   = 4'd9;
    logic [3:0] q0[$];
    logic [3:0] q1[$];

    rx_os_tracker #(
        .SLOS_REQ   (SLOS_REQ),
        .TS_REQ     (TS_REQ),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .track_en  (track_en),
        .exp_os    (exp_os),
        .lane1_en  (lane1_en),
        .os_in_l0  (os_in_l0),
        .os_in_l1  (os_in_l1),
        .d_sel     (d_sel),
        .lane_rx_on(lane_rx_on),
        .os_done   (os_done),
        .os_timeout(os_timeout)
    );

    assign w_dut = {d_sel, lane_rx_on, os_done, os_timeout};

    always #5 clk = ~clk;

    function automatic logic [6:0] model_out();
        logic rx;
        rx = (m_phase == PH_ARM) || (m_phase == PH_TRACK) || (m_phase == PH_DATA);
        return {m_sel, rx, (m_phase == PH_DONE), (m_phase == PH_TOUT)};
    endfunction

    // Hits on a lane = trailing run of matching codes, ignoring "none" (9),
    // stopped by any other code, capped at the required count.
    function automatic int hits(input logic [3:0] q[$], input logic [3:0] sel, input int need);
        int n;
        n = 0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i] == sel) begin
                n++;
            end else if (q[i] != 4'd9) begin
                break;
            end
        end
        return (n > need) ? need : n;
    endfunction

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got d_sel=%0d rx_on=%b done=%b tout=%b, want d_sel=%0d rx_on=%b done=%b tout=%b",
                     name, $time, act[6:3], act[2], act[1], act[0], exp[6:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Advance the model by one clock edge with the inputs present at that edge.
    task automatic model_step(input logic te, input logic [3:0] eo, input logic l1,
                              input logic [3:0] c0, input logic [3:0] c1);
        int need;
        int h0;
        int h1;
        if (!(te && (eo <= 4'd8))) begin
            m_phase = PH_IDLE;
            q0.delete();
            q1.delete();
        end else if (m_phase == PH_IDLE ||
                     ((m_phase == PH_TRACK || m_phase == PH_DATA ||
                       m_phase == PH_DONE  || m_phase == PH_TOUT) && eo != m_sel)) begin
            m_sel   = eo;
            m_phase = (eo == 4'd8) ? PH_DATA : PH_ARM;
            q0.delete();
            q1.delete();
        end else if (m_phase == PH_ARM) begin
            m_phase = PH_TRACK;
        end else if (m_phase == PH_TRACK) begin
            need = (m_sel <= 4'd1) ? SLOS_REQ : TS_REQ;
            h0   = hits(q0, m_sel, need);
            h1   = hits(q1, m_sel, need);
            if (h0 >= need && (h1 >= need || !l1)) begin
                m_phase = PH_DONE;
            end else if (q0.size() == TIMEOUT_CYC - 1) begin
                m_phase = PH_TOUT;
            end else begin
                q0.push_back(c0);
                q1.push_back(c1);
            end
        end
    endtask

    // Drive one cycle of inputs, update the model, and return just after the edge.
    task automatic step(input int te, input int eo, input int l1, input int c0, input int c1);
        @(negedge clk);
        track_en = te[0];
        exp_os   = 4'(eo);
        lane1_en = l1[0];
        os_in_l0 = 4'(c0);
        os_in_l1 = 4'(c1);
        model_step(track_en, exp_os, lane1_en, os_in_l0, os_in_l1);
        cmp_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_mid_cycle();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset", w_dut, {4'd9, 1'b0, 1'b0, 1'b0});
        cmp_en   = 1'b0;
        m_phase  = PH_IDLE;
        m_sel    = 4'd9;
        q0.delete();
        q1.delete();
        track_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic int pick(input logic [3:0] e);
        int r;
        r = $urandom_range(0, 99);
        if (r < 50) begin
            return int'(e);
        end else if (r < 85) begin
            return 9;
        end else begin
            return $urandom_range(0, 8);
        end
    endfunction

    // Per-cycle comparison of DUT outputs against the model.
    always @(posedge clk) begin
        #2;
        if (cmp_en && rst) begin
            chk("cycle", w_dut, model_out());
        end
    end

    initial begin
        logic [3:0] cur_exp;
        logic       cur_l1;
        int         te;

        // Power-on reset
        #2 rst = 1'b0;
        #2 chk("reset_state", w_dut, {4'd9, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        rst = 1'b1;

        // Gen3 TS1, both lanes, four hits each with gaps
        step(1, 2, 1, 9, 9);
        chk("ts_arm", w_dut, {4'd2, 1'b1, 1'b0, 1'b0});
        step(1, 2, 1, 9, 9);
        step(1, 2, 1, 2, 2);
        step(1, 2, 1, 9, 2);
        step(1, 2, 1, 2, 9);
        step(1, 2, 1, 2, 2);
        step(1, 2, 1, 2, 2);
        chk("ts_not_yet", w_dut, {4'd2, 1'b1, 1'b0, 1'b0});
        step(1, 2, 1, 9, 9);
        chk("ts_done", w_dut, {4'd2, 1'b0, 1'b1, 1'b0});

        // SLOS1, lane 1 run broken by a foreign code
        step(0, 0, 1, 9, 9);
        chk("drop_to_idle", w_dut, {4'd2, 1'b0, 1'b0, 1'b0});
        step(1, 0, 1, 9, 9);
        step(1, 0, 1, 9, 9);
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 3);
        step(1, 0, 1, 9, 0);
        step(1, 0, 1, 9, 9);
        chk("slos_lane1_reset", w_dut, {4'd0, 1'b1, 1'b0, 1'b0});
        step(1, 0, 1, 9, 0);
        step(1, 0, 1, 9, 9);
        chk("slos_done", w_dut, {4'd0, 1'b0, 1'b1, 1'b0});

        // Re-latch from DONE, then time out with no detections
        step(1, 5, 1, 9, 9);
        chk("relatch_from_done", w_dut, {4'd5, 1'b1, 1'b0, 1'b0});
        step(1, 5, 1, 9, 9);
        for (int i = 0; i < TIMEOUT_CYC - 1; i++) step(1, 5, 1, 9, 9);
        chk("tout_not_yet", w_dut, {4'd5, 1'b1, 1'b0, 1'b0});
        step(1, 5, 1, 9, 9);
        chk("tout", w_dut, {4'd5, 1'b0, 1'b0, 1'b1});

        // Lane 0 only, lane 1 silent
        step(0, 4, 0, 9, 9);
        step(1, 4, 0, 9, 9);
        step(1, 4, 0, 9, 9);
        for (int i = 0; i < TS_REQ; i++) step(1, 4, 0, 4, 9);
        chk("lane0_only_pending", w_dut, {4'd4, 1'b1, 1'b0, 1'b0});
        step(1, 4, 0, 9, 9);
        chk("lane0_only_done", w_dut, {4'd4, 1'b0, 1'b1, 1'b0});

        // Completion in the last budget cycle: done wins over timeout
        step(0, 0, 1, 9, 9);
        step(1, 0, 1, 9, 9);
        step(1, 0, 1, 9, 9);
        for (int i = 0; i < TIMEOUT_CYC - 3; i++) step(1, 0, 1, 9, 9);
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        chk("coincide_pending", w_dut, {4'd0, 1'b1, 1'b0, 1'b0});
        step(1, 0, 1, 9, 9);
        chk("coincide_done", w_dut, {4'd0, 1'b0, 1'b1, 1'b0});

        // Reset mid-TRACK, then data mode
        step(0, 3, 1, 9, 9);
        step(1, 3, 1, 9, 9);
        step(1, 3, 1, 9, 9);
        step(1, 3, 1, 3, 3);
        reset_mid_cycle();
        step(1, 8, 1, 9, 9);
        chk("data_mode", w_dut, {4'd8, 1'b1, 1'b0, 1'b0});
        for (int i = 0; i < 6; i++) step(1, 8, 1, 8, 8);
        chk("data_no_count", w_dut, {4'd8, 1'b1, 1'b0, 1'b0});
        step(1, 6, 1, 9, 9);
        chk("relatch_from_data", w_dut, {4'd6, 1'b1, 1'b0, 1'b0});

        // Randomized phase
        cur_exp = 4'd2;
        cur_l1  = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            te = ($urandom_range(0, 99) < 96) ? 1 : 0;
            if ($urandom_range(0, 99) < 4) cur_exp = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) < 3) cur_l1 = ~cur_l1;
            step(te, int'(cur_exp), int'(cur_l1), pick(cur_exp), pick(cur_exp));
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
